// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core / external loader) arbiter in front of a single
// synchronous data memory.
//
// The FSM arbitrates whenever a new request can be accepted, registers the
// winner's address, data and write enable toward the memory, and pulses the
// winner's grant for one cycle. A read spends one cycle in StIssue and one in
// StReadWait. At the end of StReadWait the memory output is latched into rdata
// and the owner's rvalid pulses.
//
// Build option: define DMEM_ARB_RR_EN to alternate contested grants between the
// ports using a last-winner register. Without it the core always wins a tie.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   core_req_i/we/addr/wdata  core request (held until core_gnt_o)
//   core_gnt_o, core_rvalid_o core grant / read-valid pulses
//   ext_req_i/we/addr/wdata   external loader request
//   ext_gnt_o, ext_rvalid_o   external grant / read-valid pulses
//   rdata_o                 registered read data shared by both ports
//   mem_addr_o/mem_data_o/mem_wren_o  registered memory command
//   mem_q_i                 memory read data (one cycle after address)
//   busy_o                  high in StIssue or StReadWait
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_gnt_o,
  output logic              ext_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wren_o,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StReadWait} state_e;

  state_e              state_q;
  logic                core_gnt_q, ext_gnt_q;
  logic                core_rvalid_q, ext_rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_data_q;
  logic                mem_wren_q;
  logic                rd_owner_ext_q;  // owner of the read currently in flight
`ifdef DMEM_ARB_RR_EN
  logic                last_ext_q;      // 1: ext won the most recent grant
`endif

  logic                arb_edge;
  logic                any_req;
  logic                pick_ext;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  always_comb begin
    // Only the edge closing a read's issue cycle is not an arbitration point;
    // mem_wren_q distinguishes a write issue from a read issue.
    arb_edge = (state_q != StIssue) || mem_wren_q;
    any_req  = core_req_i | ext_req_i;
`ifdef DMEM_ARB_RR_EN
    pick_ext = ext_req_i & (~core_req_i | ~last_ext_q);
`else
    pick_ext = ext_req_i & ~core_req_i;
`endif
    win_we    = pick_ext ? ext_we_i    : core_we_i;
    win_addr  = pick_ext ? ext_addr_i  : core_addr_i;
    win_wdata = pick_ext ? ext_wdata_i : core_wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      core_gnt_q     <= 1'b0;
      ext_gnt_q      <= 1'b0;
      core_rvalid_q  <= 1'b0;
      ext_rvalid_q   <= 1'b0;
      rdata_q        <= '0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      mem_wren_q     <= 1'b0;
      rd_owner_ext_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_ext_q     <= 1'b1;
`endif
    end else begin
      // Pulses default low; they are set only for the cycle that follows.
      core_gnt_q    <= 1'b0;
      ext_gnt_q     <= 1'b0;
      core_rvalid_q <= 1'b0;
      ext_rvalid_q  <= 1'b0;
      mem_wren_q    <= 1'b0;

      if (state_q == StReadWait) begin
        rdata_q <= mem_q_i;
        if (rd_owner_ext_q) begin
          ext_rvalid_q <= 1'b1;
        end else begin
          core_rvalid_q <= 1'b1;
        end
      end

      if (arb_edge) begin
        if (any_req) begin
          state_q        <= StIssue;
          mem_addr_q     <= win_addr;
          mem_data_q     <= win_wdata;
          mem_wren_q     <= win_we;
          rd_owner_ext_q <= pick_ext;
          core_gnt_q     <= ~pick_ext;
          ext_gnt_q      <= pick_ext;
`ifdef DMEM_ARB_RR_EN
          last_ext_q     <= pick_ext;
`endif
        end else begin
          state_q <= StIdle;
        end
      end else begin
        state_q <= StReadWait;
      end
    end
  end

  assign core_gnt_o    = core_gnt_q;
  assign ext_gnt_o     = ext_gnt_q;
  assign core_rvalid_o = core_rvalid_q;
  assign ext_rvalid_o  = ext_rvalid_q;
  assign rdata_o       = rdata_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;
  assign mem_wren_o    = mem_wren_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// two-port traffic, all checked every cycle against a transaction-level model.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        core_req, core_we, ext_req, ext_we;
  logic [15:0] core_addr, ext_addr;
  logic [31:0] core_wdata, ext_wdata;
  logic        core_gnt, core_rvalid, ext_gnt, ext_rvalid;
  logic [31:0] rdata, mem_data, mem_q;
  logic [15:0] mem_addr;
  logic        mem_wren, busy;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
    .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr),
    .ext_wdata_i(ext_wdata), .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid),
    .rdata_o(rdata), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .mem_wren_o(mem_wren), .mem_q_i(mem_q), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initf(input logic [15:0] a);
    return 32'hC0DE_0000 | {16'h0, a};
  endfunction

  // Synchronous data memory seen by the DUT.
  logic [31:0] dmem [256];
  bit          dseen [256];
  always @(posedge clk) begin
    if (mem_wren) begin
      dmem[mem_addr[7:0]]  <= mem_data;
      dseen[mem_addr[7:0]] <= 1'b1;
    end
    mem_q <= dseen[mem_addr[7:0]] ? dmem[mem_addr[7:0]] : initf(mem_addr);
  end

  // Reference model: each edge either accepts one transaction or is blocked
  // because a read was accepted on the previous edge. Reads are resolved at
  // acceptance time and delivered two edges later.
  bit          m_core_gnt, m_ext_gnt, m_core_rv, m_ext_rv, m_wren, m_busy, m_last_ext;
  logic [15:0] m_addr;
  logic [31:0] m_data, m_rdata;
  logic [31:0] ref_mem [256];
  bit          ref_seen [256];
  bit          pend, pend_ext;
  logic [31:0] pend_data;
  int          pend_blk, pend_done, ecnt;
  bit          t_arb, t_gr, t_wext, t_we;
  logic [15:0] t_a;
  logic [31:0] t_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_core_gnt = 0; m_ext_gnt = 0; m_core_rv = 0; m_ext_rv = 0;
      m_wren = 0; m_busy = 0; m_addr = '0; m_data = '0; m_rdata = '0;
      m_last_ext = 1; pend = 0;
    end else begin
      m_core_gnt = 0; m_ext_gnt = 0; m_core_rv = 0; m_ext_rv = 0; m_wren = 0;
      if (pend && ecnt == pend_done) begin
        m_rdata = pend_data;
        if (pend_ext) m_ext_rv = 1; else m_core_rv = 1;
        pend = 0;
      end
      t_arb = !(pend && ecnt == pend_blk);
      t_gr  = 0;
      if (t_arb && (core_req || ext_req)) begin
        if (core_req && ext_req) begin
          t_wext = 0;
`ifdef DMEM_ARB_RR_EN
          t_wext = !m_last_ext;
`endif
        end else begin
          t_wext = ext_req;
        end
        t_gr = 1;
        m_last_ext = t_wext;
        if (t_wext) m_ext_gnt = 1; else m_core_gnt = 1;
        t_a  = t_wext ? ext_addr : core_addr;
        t_d  = t_wext ? ext_wdata : core_wdata;
        t_we = t_wext ? ext_we : core_we;
        m_addr = t_a;
        m_data = t_d;
        if (t_we) begin
          m_wren = 1;
          ref_mem[t_a[7:0]]  = t_d;
          ref_seen[t_a[7:0]] = 1;
        end else begin
          pend      = 1;
          pend_ext  = t_wext;
          pend_data = ref_seen[t_a[7:0]] ? ref_mem[t_a[7:0]] : initf(t_a);
          pend_blk  = ecnt + 1;
          pend_done = ecnt + 2;
        end
      end
      m_busy = t_gr || !t_arb;
      ecnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".core_gnt"},    {31'h0, core_gnt},    {31'h0, m_core_gnt});
    chk({tag, ".ext_gnt"},     {31'h0, ext_gnt},     {31'h0, m_ext_gnt});
    chk({tag, ".core_rvalid"}, {31'h0, core_rvalid}, {31'h0, m_core_rv});
    chk({tag, ".ext_rvalid"},  {31'h0, ext_rvalid},  {31'h0, m_ext_rv});
    chk({tag, ".mem_wren"},    {31'h0, mem_wren},    {31'h0, m_wren});
    chk({tag, ".busy"},        {31'h0, busy},        {31'h0, m_busy});
    chk({tag, ".mem_addr"},    {16'h0, mem_addr},    {16'h0, m_addr});
    chk({tag, ".mem_data"},    mem_data,             m_data);
    chk({tag, ".rdata"},       rdata,                m_rdata);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic set_core(input logic r, input logic w, input logic [15:0] a,
                          input logic [31:0] d);
    core_req = r; core_we = w; core_addr = a; core_wdata = d;
  endtask

  task automatic set_ext(input logic r, input logic w, input logic [15:0] a,
                         input logic [31:0] d);
    ext_req = r; ext_we = w; ext_addr = a; ext_wdata = d;
  endtask

  // Random requester: holds a pending request, otherwise may issue a new one
  // (including in its grant cycle).
  task automatic rand_port(input bit gnt_now, inout logic req, inout logic we,
                           inout logic [15:0] addr, inout logic [31:0] data);
    if (gnt_now || !req) begin
      req  = ($urandom_range(0, 2) != 0);
      we   = 1'($urandom_range(0, 1));
      addr = 16'($urandom_range(0, 63));
      data = $urandom;
    end
  endtask

  logic exp_c;

  initial begin
    rst = 1'b1;
    set_core(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.busy_zero", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    step("idle");

    // Core write from idle.
    set_core(1, 1, 16'h0010, 32'hDEADBEEF);
    step("cw");
    chk("cw.gnt", {31'h0, core_gnt}, 32'h1);
    chk("cw.wren", {31'h0, mem_wren}, 32'h1);
    chk("cw.addr", {16'h0, mem_addr}, 32'h0010);
    chk("cw.data", mem_data, 32'hDEADBEEF);
    set_core(0, 0, 0, 0);
    step("cw_idle");
    chk("cw.idle_busy", {31'h0, busy}, 32'h0);

    // Ext preload then ext read.
    set_ext(1, 1, 16'h0020, 32'h12345678);
    step("ew");
    set_ext(1, 0, 16'h0020, 32'h0);
    step("er_gnt");
    chk("er.gnt", {31'h0, ext_gnt}, 32'h1);
    set_ext(0, 0, 0, 0);
    step("er_wait");
    chk("er.wait_busy", {31'h0, busy}, 32'h1);
    chk("er.wait_rv", {31'h0, ext_rvalid}, 32'h0);
    step("er_data");
    chk("er.rvalid", {31'h0, ext_rvalid}, 32'h1);
    chk("er.rdata", rdata, 32'h12345678);
    chk("er.core_rv", {31'h0, core_rvalid}, 32'h0);

    // Contested writes for four edges.
    set_core(1, 1, 16'h0040, 32'h1111_0000);
    set_ext(1, 1, 16'h0041, 32'h2222_0000);
    for (int i = 0; i < 4; i++) begin
      step("both");
      exp_c = 1'b1;
`ifdef DMEM_ARB_RR_EN
      exp_c = (i % 2 == 0);
`endif
      chk($sformatf("both%0d.core_gnt", i), {31'h0, core_gnt}, {31'h0, exp_c});
      chk($sformatf("both%0d.ext_gnt", i), {31'h0, ext_gnt}, {31'h0, ~exp_c});
    end
    set_core(0, 0, 0, 0);
    step("ext_after");
    chk("ext_after.gnt", {31'h0, ext_gnt}, 32'h1);
    set_ext(0, 0, 0, 0);
    step("both_idle");

    // Core read then write: write grant lands on the rvalid cycle.
    set_core(1, 0, 16'h0010, 32'h0);
    step("rw_gnt");
    chk("rw.rd_gnt", {31'h0, core_gnt}, 32'h1);
    set_core(1, 1, 16'h0030, 32'hCAFEF00D);
    step("rw_wait");
    chk("rw.wait_gnt", {31'h0, core_gnt}, 32'h0);
    step("rw_both");
    chk("rw.rvalid", {31'h0, core_rvalid}, 32'h1);
    chk("rw.wgnt", {31'h0, core_gnt}, 32'h1);
    chk("rw.wren", {31'h0, mem_wren}, 32'h1);
    chk("rw.rdata", rdata, 32'hDEADBEEF);
    set_core(0, 0, 0, 0);
    step("rw_idle");

    // Reset during READ_WAIT discards the read.
    set_core(1, 0, 16'h0030, 32'h0);
    step("rr_gnt");
    set_core(0, 0, 0, 0);
    step("rr_wait");
    chk("rr.wait_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check_all("rr_rst");
    chk("rr.rst_busy", {31'h0, busy}, 32'h0);
    chk("rr.rst_addr", {16'h0, mem_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("rr_after");
      chk("rr.no_rvalid", {31'h0, core_rvalid}, 32'h0);
    end
    set_core(1, 1, 16'h0050, 32'h0BADCAFE);
    step("rr_new");
    chk("rr.new_gnt", {31'h0, core_gnt}, 32'h1);
    set_core(0, 0, 0, 0);
    step("rr_idle");

    // Random two-port traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rand_port(m_core_gnt, core_req, core_we, core_addr, core_wdata);
      rand_port(m_ext_gnt, ext_req, ext_we, ext_addr, ext_wdata);
      @(negedge clk);
      check_all("rand");
      if (i == 1500) begin
        #2;
        rst = 1'b1;
        #1;
        check_all("rand_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, data memory word-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 core_req  input  1  core load/store request; held until core_gnt is seen.
REQ-006 core_we  input  1  core request type: 1 = write, 0 = read.
REQ-007 core_addr  input  ADDR_W  core word address.
REQ-008 core_wdata  input  DATA_W  core write data.
REQ-009 core_gnt  output  1  one-cycle pulse; core request accepted.
REQ-010 core_rvalid  output  1  one-cycle pulse; core read data valid on rdata.
REQ-011 ext_req, ext_we, ext_addr, ext_wdata  input  1/1/ADDR_W/DATA_W  external (program loader) port, same semantics as core.
REQ-012 ext_gnt, ext_rvalid  output  1/1  external port grant and read-valid pulses.
REQ-013 rdata  output  DATA_W  registered read data shared by both ports; qualified only by the owning rvalid.
REQ-014 mem_addr  output  ADDR_W  registered address to data memory.
REQ-015 mem_data  output  DATA_W  registered write data to data memory.
REQ-016 mem_wren  output  1  registered memory write enable.
REQ-017 mem_q  input  DATA_W  memory read data, valid one cycle after mem_addr is presented.
REQ-018 busy  output  1  high while state is ISSUE or READ_WAIT.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ISSUE, READ_WAIT.
REQ-020 Arbitration SHALL occur at every rising edge where state is IDLE, ISSUE with a write in progress, or READ_WAIT.
REQ-021 At an arbitration edge with no request, the next state SHALL be IDLE.
REQ-022 At an arbitration edge with at least one request, the arbiter SHALL register winner addr/wdata/we into mem_addr/mem_data/mem_wren, assert the winner's gnt for the following cycle only, and enter ISSUE.
REQ-023 A lone requester SHALL always win; the two-requester winner is defined under Configuration.
REQ-024 mem_wren SHALL be 1 only during an ISSUE cycle of a write; mem_addr/mem_data SHALL hold their last values otherwise.
REQ-025 ISSUE for a read SHALL be followed unconditionally by READ_WAIT; no arbitration occurs at that edge.
REQ-026 At the edge ending READ_WAIT, rdata SHALL capture mem_q and the read owner's rvalid SHALL pulse for exactly the following cycle.
REQ-027 Latency: request sampled at edge k -> gnt and mem drive in cycle k; read data on rdata with rvalid in cycle k+2.
REQ-028 Throughput: back-to-back writes one per cycle; reads one per two cycles; a new ISSUE MAY coincide with an rvalid cycle.
REQ-029 A req still high at the edge ending its gnt cycle SHALL be treated as a new request.
REQ-030 core_gnt and ext_gnt SHALL never be high together; likewise core_rvalid and ext_rvalid.

Reset
REQ-031 rst SHALL immediately force IDLE, core_gnt=ext_gnt=0, core_rvalid=ext_rvalid=0, mem_wren=0, busy=0, mem_addr=0, mem_data=0, rdata=0.
REQ-032 A read in ISSUE or READ_WAIT when rst asserts SHALL be discarded; no rvalid is issued for it after reset release.
REQ-033 The round-robin last-winner register SHALL reset to "ext", so the core wins the first contested arbitration.

Configuration
REQ-034 Macro DMEM_ARB_RR_EN defined: contested arbitration SHALL grant the port that did not win the most recent grant (alternation).
REQ-035 DMEM_ARB_RR_EN undefined: contested arbitration SHALL always grant the core; the last-winner register SHALL be absent.

Verification
REQ-036 Core write addr 0x0010 data 0xDEADBEEF from IDLE -> core_gnt and mem_wren=1 one cycle after sampling edge, mem_addr=0x0010, mem_data=0xDEADBEEF, then IDLE.
REQ-037 Ext read addr 0x0020 with memory holding 0x12345678 -> ext_gnt cycle k, READ_WAIT cycle k+1, ext_rvalid=1 with rdata=0x12345678 cycle k+2, core_rvalid=0.
REQ-038 Both ports hold write requests for 4 edges: with DMEM_ARB_RR_EN grants core,ext,core,ext; without it grants core x4, ext only after core_req drops.
REQ-039 Core read immediately followed by core write -> write gnt in the same cycle as read rvalid; mem_wren=1 in that cycle.
REQ-040 rst asserted during READ_WAIT of a core read -> all outputs zero at once, no core_rvalid after rst deasserts, next request granted normally.
